// File: rtl/count_sequencer.sv
// Bounded up/down/wrap/ping-pong counter sequencer with a prescaled step rate.
// Runs between latched bounds lo..hi and reports one-shot completion and rejected starts.
module count_sequencer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  output logic [3:0] q,
  output logic       up,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] LAST = 8'(PRESCALE - 1);

  state_t     state, state_n;
  logic [3:0] q_n, lo_r, lo_n, hi_r, hi_n;
  logic [1:0] mode_r, mode_n;
  logic [7:0] presc, presc_n;
  logic       up_n, done_n, err_n;
  logic       tick;

  assign busy = (state == RUN);
  assign tick = (presc == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      up     <= 1'b1;
      done   <= 1'b0;
      err    <= 1'b0;
      presc  <= '0;
      lo_r   <= '0;
      hi_r   <= '0;
      mode_r <= '0;
    end else begin
      state  <= state_n;
      q      <= q_n;
      up     <= up_n;
      done   <= done_n;
      err    <= err_n;
      presc  <= presc_n;
      lo_r   <= lo_n;
      hi_r   <= hi_n;
      mode_r <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    q_n     = q;
    up_n    = up;
    done_n  = 1'b0;
    err_n   = 1'b0;
    presc_n = presc;
    lo_n    = lo_r;
    hi_n    = hi_r;
    mode_n  = mode_r;

    case (state)
      IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          if (lo <= hi) begin
            state_n = RUN;
            mode_n  = mode;
            lo_n    = lo;
            hi_n    = hi;
            presc_n = '0;
            if (mode == 2'b01) begin
              q_n  = hi;
              up_n = 1'b0;
            end else begin
              q_n  = lo;
              up_n = 1'b1;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (!pause) begin
          if (!tick) begin
            presc_n = presc + 8'd1;
          end else begin
            presc_n = '0;
            case (mode_r)
              2'b00: begin
                if (q == hi_r) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                end else begin
                  q_n = q + 4'd1;
                end
              end
              2'b01: begin
                if (q == lo_r) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                end else begin
                  q_n = q - 4'd1;
                end
              end
              2'b10: begin
                q_n = (q == hi_r) ? lo_r : q + 4'd1;
              end
              default: begin
                // a single-value range only flips direction so q stays in bounds
                if (lo_r == hi_r) begin
                  up_n = ~up;
                end else if (up && (q == hi_r)) begin
                  up_n = 1'b0;
                  q_n  = q - 4'd1;
                end else if (!up && (q == lo_r)) begin
                  up_n = 1'b1;
                  q_n  = q + 4'd1;
                end else begin
                  q_n = up ? q + 4'd1 : q - 4'd1;
                end
              end
            endcase
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter PRESCALE, default 1, cycles per count step, legal range 1..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  run request, sampled every cycle.
REQ-005 stop  in  1  abort request, sampled every cycle.
REQ-006 pause  in  1  level; freezes stepping while high.
REQ-007 mode  in  2  00 one-shot up, 01 one-shot down, 10 wrap up, 11 ping-pong.
REQ-008 lo  in  4  lower count bound, unsigned.
REQ-009 hi  in  4  upper count bound, unsigned.
REQ-010 q  out  4  current count, registered.
REQ-011 up  out  1  current direction, 1 = up, registered.
REQ-012 busy  out  1  high while in RUN.
REQ-013 done  out  1  one-cycle pulse at one-shot completion.
REQ-014 err  out  1  one-cycle pulse on rejected start.

Function
REQ-015 The block SHALL be an FSM with states IDLE and RUN; busy SHALL equal (state == RUN).
REQ-016 In IDLE with start=1 and lo<=hi, the block SHALL latch mode/lo/hi, enter RUN, clear the prescaler, and set q=hi, up=0 for mode 01, or q=lo, up=1 otherwise, all visible the next cycle.
REQ-017 In IDLE with start=1 and lo>hi, the block SHALL pulse err for one cycle, stay in IDLE, and leave q/up unchanged.
REQ-018 In RUN, mode/lo/hi inputs SHALL be ignored; only latched copies SHALL be used.
REQ-019 In RUN, start SHALL be ignored.
REQ-020 Prescaler: 8-bit counter 0..PRESCALE-1; tick when it equals PRESCALE-1, then wrap to 0; first step SHALL occur PRESCALE cycles after q takes its start value.
REQ-021 While pause=1, prescaler and q/up SHALL hold; stepping SHALL resume from the held prescaler value.
REQ-022 Mode 00 on tick: q==hi -> done pulse, enter IDLE, q holds; else q+1.
REQ-023 Mode 01 on tick: q==lo -> done pulse, enter IDLE, q holds; else q-1.
REQ-024 Mode 10 on tick: q==hi -> q=lo; else q+1; never completes.
REQ-025 Mode 11 on tick: at q==hi with up=1 or q==lo with up=0, up SHALL invert and q SHALL step once in the new direction; otherwise q steps in direction up; never completes.
REQ-026 lo==hi: modes 00/01 SHALL complete on the first tick; modes 10/11 SHALL hold q, and mode 11 SHALL toggle up each tick.
REQ-027 q arithmetic SHALL be 4-bit; q SHALL never leave [lo,hi] while in RUN.
REQ-028 stop=1 in RUN SHALL enter IDLE next cycle with q/up held and no done pulse; stop SHALL take priority over a same-cycle tick.
REQ-029 stop in IDLE SHALL have no effect; simultaneous start and stop in IDLE SHALL be treated as stop (no start).
REQ-030 done and err SHALL never be high in the same cycle and SHALL be low at all other times.

Reset
REQ-031 rst=1 SHALL force, on the next edge: state IDLE, q=0, up=1, busy=0, done=0, err=0, prescaler=0, latched lo/hi/mode=0.
REQ-032 rst SHALL override start, stop, pause and any in-progress run, including one in mid-prescale.

Verification
REQ-033 PRESCALE=1, mode 00, lo=3 hi=6, start pulse -> q 3,4,5,6 on consecutive cycles; done=1 one cycle after q=6 is evaluated; busy falls with it; q stays 6.
REQ-034 PRESCALE=1, mode 11, lo=2 hi=4 -> q 2,3,4,3,2,3,4; up 1,1,1,0,0,1,1; done never asserts.
REQ-035 PRESCALE=1, mode 10, lo=0 hi=15 -> q ...14,15,0,1; then stop -> busy=0 next cycle, q holds, no done.
REQ-036 lo=5 hi=2, start -> err one cycle, busy stays 0, q unchanged.
REQ-037 PRESCALE=3, mode 01, lo=0 hi=3 -> q steps every 3 cycles 3,2,1,0 then done; pause held 5 cycles mid-run delays completion by exactly 5 cycles.
REQ-038 rst asserted mid-run (mode 11) -> next cycle q=0, up=1, busy=0; a start with the same lo/hi afterward restarts from lo.
